// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
//   Shared definitions for the push-button conditioner.
//   - QUAL_CNT_W : width of the debounce qualification counter
//   - HOLD_CNT_W : width of the hold / auto-repeat counter
//   - btn_state_t: conditioner FSM state encoding (also exported on the
//                  debug state output of button_conditioner)
// ---------------------------------------------------------------------------
package button_pkg;

  localparam int QUAL_CNT_W = 24;
  localparam int HOLD_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_QUAL   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_QUAL = 2'd3
  } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer bringing an asynchronous level into the clk domain.
//   Ports:
//     clk      in  system clock, rising edge
//     reset_n  in  asynchronous active-low reset, clears both flops
//     async_in in  asynchronous input level
//     sync_out out synchronized level (second flop), two-edge latency
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Debounces a raw push-button and produces a clean level plus one-cycle
//   press / release pulses, with optional auto-repeat press pulses while held.
//   Parameters:
//     DEBOUNCE_CYCLES  cycles s_in must stay stable to qualify (2..2^24-1)
//     REPEAT_EN        1 enables auto-repeat press pulses while held
//     HOLD_CYCLES      held time (in PRESSED) before the first repeat pulse
//     REPEAT_CYCLES    spacing between subsequent repeat pulses
//   Ports:
//     clk           in  single system clock, rising edge
//     reset_n       in  asynchronous assert, active-low reset
//     btn_in        in  raw, bouncing, asynchronous, active-high button
//     btn_level     out debounced button level (registered)
//     press_pulse   out one-cycle pulse per qualified press and per repeat
//     release_pulse out one-cycle pulse per qualified release
//     dbg_state     out current FSM state (btn_state_t encoding)
//   Clean-input latency from a btn_in edge to the matching pulse is
//   DEBOUNCE_CYCLES+3 edges: two synchronizer edges, one edge leaving
//   IDLE/PRESSED, then DEBOUNCE_CYCLES qualification edges.
// ---------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] dbg_state
);

  localparam logic [QUAL_CNT_W-1:0] QUAL_LAST  = QUAL_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_FIRST = HOLD_CNT_W'(HOLD_CYCLES);
  localparam logic [HOLD_CNT_W-1:0] HOLD_NEXT  = HOLD_CNT_W'(HOLD_CYCLES + REPEAT_CYCLES);

  logic s_in;

  btn_state_t            state_q,         state_d;
  logic [QUAL_CNT_W-1:0] qual_cnt_q,      qual_cnt_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q,      hold_cnt_d;
  logic                  btn_level_q,     btn_level_d;
  logic                  press_pulse_q,   press_pulse_d;
  logic                  release_pulse_q, release_pulse_d;

  logic [QUAL_CNT_W-1:0] qual_cnt_inc;
  logic [HOLD_CNT_W-1:0] hold_cnt_inc;

  sync_2ff u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (btn_in),
    .sync_out (s_in)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      qual_cnt_q      <= '0;
      hold_cnt_q      <= '0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      qual_cnt_q      <= qual_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    qual_cnt_d      = qual_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    btn_level_d     = btn_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;

    // Qualification counter sticks at all-ones instead of wrapping.
    qual_cnt_inc = (qual_cnt_q == '1) ? qual_cnt_q : qual_cnt_q + QUAL_CNT_W'(1);
    hold_cnt_inc = hold_cnt_q + HOLD_CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (s_in) begin
          state_d    = ST_PRESS_QUAL;
          qual_cnt_d = '0;
        end
      end

      ST_PRESS_QUAL: begin
        if (!s_in) begin
          state_d = ST_IDLE;
        end else if (qual_cnt_q == QUAL_LAST) begin
          state_d       = ST_PRESSED;
          btn_level_d   = 1'b1;
          press_pulse_d = 1'b1;
        end else begin
          qual_cnt_d = qual_cnt_inc;
        end
      end

      ST_PRESSED: begin
        if (!s_in) begin
          state_d    = ST_RELEASE_QUAL;
          qual_cnt_d = '0;
        end else if (REPEAT_EN != 0) begin
          // Hold counter only advances on cycles spent held in PRESSED, so a
          // RELEASE_QUAL excursion freezes it. After the first repeat it is
          // reloaded to HOLD_FIRST so it cycles through one repeat period.
          // A pulse is suppressed if one was just issued, so pulses are
          // never back to back even with degenerate parameters.
          if (hold_cnt_inc == HOLD_NEXT) begin
            hold_cnt_d    = HOLD_FIRST;
            press_pulse_d = ~press_pulse_q;
          end else begin
            hold_cnt_d = hold_cnt_inc;
            if (hold_cnt_inc == HOLD_FIRST) begin
              press_pulse_d = ~press_pulse_q;
            end
          end
        end
      end

      ST_RELEASE_QUAL: begin
        if (s_in) begin
          state_d = ST_PRESSED;
        end else if (qual_cnt_q == QUAL_LAST) begin
          state_d         = ST_IDLE;
          btn_level_d     = 1'b0;
          release_pulse_d = 1'b1;
          hold_cnt_d      = '0;
        end else begin
          qual_cnt_d = qual_cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, qualification length in clk cycles (10 ms at 50 MHz), legal range 2..2^24-1.
REQ-002 SHALL have parameter REPEAT_EN, default 0, 1 enables auto-repeat press pulses while held.
REQ-003 SHALL have parameter HOLD_CYCLES, default 25000000, held time before first repeat pulse.
REQ-004 SHALL have parameter REPEAT_CYCLES, default 5000000, spacing between repeat pulses.
REQ-005 SHALL have port clk  input  1  single system clock, rising edge; the only clock.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port btn_in  input  1  raw push-button, asynchronous, active-high, bouncing.
REQ-008 SHALL have port btn_level  output  1  debounced button level.
REQ-009 SHALL have port press_pulse  output  1  one-cycle pulse per qualified press, and per repeat.
REQ-010 SHALL have port release_pulse  output  1  one-cycle pulse per qualified release.

Function
REQ-011 SHALL pass btn_in through a two-flop synchronizer; the second flop output is s_in, the only value used by the FSM.
REQ-012 SHALL implement FSM states IDLE, PRESS_QUAL, PRESSED, RELEASE_QUAL; no other reachable state.
REQ-013 SHALL, in IDLE with s_in=1, go to PRESS_QUAL and clear the 24-bit qualification counter.
REQ-014 SHALL, in PRESS_QUAL, return to IDLE when s_in=0; otherwise increment the counter; when counter = DEBOUNCE_CYCLES-1 with s_in=1, go to PRESSED.
REQ-015 SHALL assert press_pulse for exactly the one cycle following entry into PRESSED, with btn_level=1 from that same cycle.
REQ-016 SHALL make btn_in-rise to press_pulse latency exactly DEBOUNCE_CYCLES+3 clk edges for a clean, bounce-free input.
REQ-017 SHALL, in PRESSED with s_in=0, go to RELEASE_QUAL and clear the counter; RELEASE_QUAL mirrors PRESS_QUAL with polarity inverted, returning to PRESSED on any s_in=1.
REQ-018 SHALL, on release qualification, enter IDLE, drop btn_level and pulse release_pulse for one cycle in the same cycle.
REQ-019 SHALL, when REPEAT_EN=1, run a 32-bit hold counter in PRESSED only, pulse press_pulse after HOLD_CYCLES, then every REPEAT_CYCLES until leaving PRESSED.
REQ-020 SHALL preserve the hold/repeat counter across a RELEASE_QUAL excursion that returns to PRESSED, and clear it on entry to IDLE.
REQ-021 SHALL never assert press_pulse and release_pulse in the same cycle, and never assert either for two consecutive cycles.
REQ-022 SHALL, with REPEAT_EN=0, emit exactly one press_pulse and one release_pulse per qualified press/release pair regardless of hold time.
REQ-023 SHALL saturate, never wrap, the qualification counter.

Reset
REQ-024 SHALL, while reset_n=0, force state IDLE, counters 0, synchronizer flops 0, btn_level=0, press_pulse=0, release_pulse=0.
REQ-025 SHALL, on reset mid-press, emit no release_pulse; after release of reset a still-held button requires full requalification and produces a press_pulse.

Structure
REQ-026 SHALL place the FSM state encoding and counter width constants in shared package button_pkg.
REQ-027 SHALL instantiate one sub-module sync_2ff (clk, reset_n, async_in, sync_out) for the synchronizer.
REQ-028 SHALL register all three outputs directly from flops; no combinational path from btn_in to any output.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-029 SHALL cover: clean btn_in rise held 50 cycles -> single press_pulse 7 edges after the rise, btn_level=1; release -> release_pulse 7 edges after the fall.
REQ-030 SHALL cover: btn_in toggling every 2 cycles for 30 cycles then low -> no pulses, btn_level stays 0.
REQ-031 SHALL cover: REPEAT_EN=1, hold 60 cycles -> press_pulses at qualification, +20, +28, +36, +44, +52; none after release.
REQ-032 SHALL cover: reset_n low for 3 cycles mid-PRESSED, button held -> outputs 0 during reset, no release_pulse, new press_pulse 7 edges after reset_n rise.
REQ-033 SHALL cover: while pressed, 2-cycle low glitch -> btn_level stays 1, no release_pulse, no extra press_pulse.
